i2c_master_read_sequencer: RTL and testbench

- Transaction-level controller that sequences an I2C master read over existing bit- and byte-level engines: condition engine (START/STOP/ACK/NACK), write-byte engine (address phase), read-byte engine (data phase).
- Accepts a command (7-bit address, byte count), runs START → addr+R → N reads with ACK/NACK → STOP, and delivers parallel bytes on a valid/ready stream.
- Owns the bus-owner select for the external scl/sda mux.
- Sits between the register/command interface and the engine layer.

---
 rtl/i2c_master_read_sequencer_pkg.sv | 36 +++
 rtl/i2c_master_read_sequencer_if.sv | 25 ++
 rtl/i2c_master_read_sequencer_rx.sv | 43 ++++
 rtl/i2c_master_read_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_master_read_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_master_read_sequencer_pkg.sv
// Shared types and encodings for the I2C master read sequencer.
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_READ,
        ST_HOLD,
        ST_ACKB,
        ST_STOP,
        ST_ABORT,
        ST_DONE
    } state_t;

    localparam logic [1:0] COND_START = 2'd0;
    localparam logic [1:0] COND_STOP  = 2'd1;
    localparam logic [1:0] COND_ACK   = 2'd2;
    localparam logic [1:0] COND_NACK  = 2'd3;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_ADDR_NACK = 2'd1;
    localparam logic [1:0] ERR_ENGINE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    localparam logic [1:0] BUS_IDLE = 2'd0;
    localparam logic [1:0] BUS_COND = 2'd1;
    localparam logic [1:0] BUS_WB   = 2'd2;
    localparam logic [1:0] BUS_RB   = 2'd3;

    // The first error of a transaction wins; later ones are dropped.
    function automatic logic [1:0] sticky_err(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur == ERR_OK) ? nxt : cur;
    endfunction

endpackage

// File: rtl/i2c_master_read_sequencer_if.sv
// Command and read-data stream between the host side and the read sequencer.
interface i2c_master_read_sequencer_if #(
    parameter int unsigned LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             busy;
    logic             done;
    logic [1:0]       err_code;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, rd_ready,
        input  cmd_ready, rd_data, rd_valid, busy, done, err_code
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, rd_ready,
        output cmd_ready, rd_data, rd_valid, busy, done, err_code
    );
endinterface

// File: rtl/i2c_master_read_sequencer_rx.sv
// MSB-first byte assembler fed by the read-byte engine's bit strobes.
module i2c_rx_byte_assembler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       bit_in,
    output logic [7:0] data,
    output logic       count_ok
);
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       count_ok_q, count_ok_d;

    // Counter saturates so an over-long burst can never alias back to 8.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            shift_d = {shift_q[6:0], bit_in};
            cnt_d   = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
        end
        count_ok_d = (cnt_d == 4'd8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            count_ok_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            count_ok_q <= count_ok_d;
        end
    end

    assign data     = shift_q;
    assign count_ok = count_ok_q;
endmodule

// File: rtl/i2c_master_read_sequencer.sv
// Transaction sequencer for an I2C master read: START, addr+R, N data bytes
// with ACK/NACK, STOP; drives the condition/write-byte/read-byte engines.
module i2c_master_read_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    i2c_master_read_sequencer_if.slave host,
    output logic       cond_go,
    output logic [1:0] cond_sel,
    input  logic       cond_finish,
    output logic       wb_go,
    output logic [7:0] wb_byte,
    input  logic       wb_finish,
    input  logic       wb_nack,
    input  logic       wb_error,
    output logic       rb_go,
    input  logic       rb_data,
    input  logic       rb_load,
    input  logic       rb_finish,
    input  logic       rb_error,
    output logic [1:0] bus_sel
);
    localparam int unsigned        TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             launched_q, launched_d;
    logic             cond_go_q, cond_go_d;
    logic             wb_go_q, wb_go_d;
    logic             rb_go_q, rb_go_d;
    logic [1:0]       cond_sel_q, cond_sel_d;
    logic [1:0]       bus_sel_q, bus_sel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [6:0]       addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             busy_q, busy_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic             fin_c;
    logic             asm_clr_c;
    logic [7:0]       asm_byte;
    logic             asm_ok;

    i2c_rx_byte_assembler u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (asm_clr_c),
        .load     (rb_load && rb_go_q),
        .bit_in   (rb_data),
        .data     (asm_byte),
        .count_ok (asm_ok)
    );

    // Engine states: one go-low cycle on entry, then go held until finish or timeout.
    always_comb begin
        state_d     = state_q;
        launched_d  = launched_q;
        cond_go_d   = cond_go_q;
        wb_go_d     = wb_go_q;
        rb_go_d     = rb_go_q;
        cond_sel_d  = cond_sel_q;
        bus_sel_d   = bus_sel_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        err_code_d  = err_code_q;
        asm_clr_c   = 1'b0;

        case (state_q)
            ST_ADDR: fin_c = wb_finish;
            ST_READ: fin_c = rb_finish;
            ST_START, ST_ACKB, ST_STOP: fin_c = cond_finish;
            default: fin_c = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (host.cmd_valid && cmd_ready_q) begin
                    addr_d  = host.cmd_addr;
                    rem_d   = host.cmd_len;
                    err_d   = ERR_OK;
                    state_d = ST_START;
                end
            end
            ST_HOLD: begin
                // SCL stays stretched until the consumer takes the byte.
                if (rd_valid_q && host.rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (rem_q != '0) rem_d = rem_q - 1'b1;
                    state_d = ST_ACKB;
                end
            end
            ST_ABORT: state_d = ST_STOP;
            ST_DONE:  state_d = ST_IDLE;
            default: begin
                if (!launched_q) begin
                    launched_d = 1'b1;
                    tmo_d      = '0;
                    case (state_q)
                        ST_START: begin
                            cond_go_d  = 1'b1;
                            cond_sel_d = COND_START;
                            bus_sel_d  = BUS_COND;
                        end
                        ST_ACKB: begin
                            cond_go_d  = 1'b1;
                            cond_sel_d = (rem_q != '0) ? COND_ACK : COND_NACK;
                            bus_sel_d  = BUS_COND;
                        end
                        ST_STOP: begin
                            cond_go_d  = 1'b1;
                            cond_sel_d = COND_STOP;
                            bus_sel_d  = BUS_COND;
                        end
                        ST_ADDR: begin
                            wb_go_d   = 1'b1;
                            bus_sel_d = BUS_WB;
                        end
                        ST_READ: begin
                            rb_go_d   = 1'b1;
                            bus_sel_d = BUS_RB;
                            asm_clr_c = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (fin_c) begin
                    cond_go_d  = 1'b0;
                    wb_go_d    = 1'b0;
                    rb_go_d    = 1'b0;
                    bus_sel_d  = BUS_IDLE;
                    launched_d = 1'b0;
                    tmo_d      = '0;
                    case (state_q)
                        ST_START: state_d = ST_ADDR;
                        ST_ADDR: begin
                            if (wb_error) begin
                                err_d   = sticky_err(err_q, ERR_ENGINE);
                                state_d = ST_ABORT;
                            end else if (wb_nack) begin
                                err_d   = sticky_err(err_q, ERR_ADDR_NACK);
                                state_d = ST_ABORT;
                            end else if (rem_q == '0) begin
                                state_d = ST_STOP;
                            end else begin
                                state_d = ST_READ;
                            end
                        end
                        ST_READ: begin
                            if (!rb_error && asm_ok) begin
                                rd_data_d  = asm_byte;
                                rd_valid_d = 1'b1;
                                state_d    = ST_HOLD;
                            end else begin
                                err_d   = sticky_err(err_q, ERR_ENGINE);
                                state_d = ST_ABORT;
                            end
                        end
                        ST_ACKB: state_d = (rem_q != '0) ? ST_READ : ST_STOP;
                        ST_STOP: state_d = ST_DONE;
                        default: ;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    cond_go_d  = 1'b0;
                    wb_go_d    = 1'b0;
                    rb_go_d    = 1'b0;
                    bus_sel_d  = BUS_IDLE;
                    launched_d = 1'b0;
                    tmo_d      = '0;
                    err_d      = sticky_err(err_q, ERR_TIMEOUT);
                    state_d    = (state_q == ST_STOP) ? ST_DONE : ST_STOP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase

        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d     = 1'b1;
            err_code_d = err_d;
        end
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            launched_q  <= 1'b0;
            cond_go_q   <= 1'b0;
            wb_go_q     <= 1'b0;
            rb_go_q     <= 1'b0;
            cond_sel_q  <= COND_START;
            bus_sel_q   <= BUS_IDLE;
            tmo_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            err_q       <= ERR_OK;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_code_q  <= ERR_OK;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            launched_q  <= launched_d;
            cond_go_q   <= cond_go_d;
            wb_go_q     <= wb_go_d;
            rb_go_q     <= rb_go_d;
            cond_sel_q  <= cond_sel_d;
            bus_sel_q   <= bus_sel_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cond_go       = cond_go_q;
    assign cond_sel      = cond_sel_q;
    assign wb_go         = wb_go_q;
    assign wb_byte       = {addr_q, 1'b1};
    assign rb_go         = rb_go_q;
    assign bus_sel       = bus_sel_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.err_code = err_code_q;
endmodule

// File: tb/tb_i2c_master_read_sequencer.sv
// Directed bench for i2c_master_read_sequencer with hand-written engine responses.
module tb_i2c_master_read_sequencer;
    logic       clk;
    logic       rst_n;
    logic       cond_go, wb_go, rb_go;
    logic [1:0] cond_sel, bus_sel;
    logic [7:0] wb_byte;
    logic       cond_finish, wb_finish, wb_nack, wb_error;
    logic       rb_data, rb_load, rb_finish, rb_error;

    int checks   = 0;
    int failures = 0;
    int rdv_cnt  = 0;
    int cgo_cnt  = 0;
    int rbr_cnt  = 0;
    logic rb_go_p = 1'b0;

    i2c_master_read_sequencer_if #(.LEN_W(8)) host_if ();

    i2c_master_read_sequencer #(.LEN_W(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host_if.slave),
        .cond_go     (cond_go),
        .cond_sel    (cond_sel),
        .cond_finish (cond_finish),
        .wb_go       (wb_go),
        .wb_byte     (wb_byte),
        .wb_finish   (wb_finish),
        .wb_nack     (wb_nack),
        .wb_error    (wb_error),
        .rb_go       (rb_go),
        .rb_data     (rb_data),
        .rb_load     (rb_load),
        .rb_finish   (rb_finish),
        .rb_error    (rb_error),
        .bus_sel     (bus_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (host_if.rd_valid === 1'b1) rdv_cnt++;
        if (cond_go === 1'b1) cgo_cnt++;
        if (rb_go === 1'b1 && rb_go_p !== 1'b1) rbr_cnt++;
        rb_go_p <= rb_go;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] addr, input logic [7:0] len, input string tag);
        check({tag, "_cmd_ready"}, 32'(host_if.cmd_ready), 32'd1);
        host_if.cmd_addr  = addr;
        host_if.cmd_len   = len;
        host_if.cmd_valid = 1'b1;
        tick();
        host_if.cmd_valid = 1'b0;
        check({tag, "_busy"}, 32'(host_if.busy), 32'd1);
    endtask

    task automatic do_cond(input logic [1:0] sel, input string tag);
        int n = 0;
        while (cond_go !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, "_go"}, 32'(cond_go), 32'd1);
        check({tag, "_sel"}, 32'(cond_sel), 32'(sel));
        check({tag, "_bus"}, 32'(bus_sel), 32'd1);
        tick();
        tick();
        cond_finish = 1'b1;
        tick();
        cond_finish = 1'b0;
        check({tag, "_drop"}, 32'(cond_go), 32'd0);
    endtask

    task automatic do_wb(input logic nack, input logic [7:0] exp_byte, input string tag);
        int n = 0;
        while (wb_go !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, "_go"}, 32'(wb_go), 32'd1);
        check({tag, "_byte"}, 32'(wb_byte), 32'(exp_byte));
        check({tag, "_bus"}, 32'(bus_sel), 32'd2);
        tick();
        wb_nack   = nack;
        wb_finish = 1'b1;
        tick();
        wb_finish = 1'b0;
        wb_nack   = 1'b0;
    endtask

    task automatic do_rb(input logic [7:0] b, input int nbits, input string tag);
        int n = 0;
        while (rb_go !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, "_go"}, 32'(rb_go), 32'd1);
        check({tag, "_bus"}, 32'(bus_sel), 32'd3);
        for (int i = 0; i < nbits; i++) begin
            rb_data = b[7-i];
            rb_load = 1'b1;
            tick();
        end
        rb_load   = 1'b0;
        rb_finish = 1'b1;
        tick();
        rb_finish = 1'b0;
    endtask

    task automatic wait_rdv(input logic [7:0] exp, input string tag);
        int n = 0;
        while (host_if.rd_valid !== 1'b1 && n < 10) begin tick(); n++; end
        check({tag, "_valid"}, 32'(host_if.rd_valid), 32'd1);
        check({tag, "_data"}, 32'(host_if.rd_data), 32'(exp));
    endtask

    task automatic wait_done(input logic [1:0] exp_err, input string tag);
        int n = 0;
        while (host_if.done !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, "_done"}, 32'(host_if.done), 32'd1);
        check({tag, "_err"}, 32'(host_if.err_code), 32'(exp_err));
        tick();
        check({tag, "_pulse"}, 32'(host_if.done), 32'd0);
        check({tag, "_idle"}, 32'(host_if.cmd_ready), 32'd1);
    endtask

    initial begin
        int base_c;
        int base_r;
        int base_v;
        int cnt;
        rst_n = 1'b0;
        host_if.cmd_valid = 1'b0;
        host_if.cmd_addr  = '0;
        host_if.cmd_len   = '0;
        host_if.rd_ready  = 1'b1;
        cond_finish = 1'b0;
        wb_finish   = 1'b0;
        wb_nack     = 1'b0;
        wb_error    = 1'b0;
        rb_data     = 1'b0;
        rb_load     = 1'b0;
        rb_finish   = 1'b0;
        rb_error    = 1'b0;
        repeat (3) tick();

        check("rst_cmd_ready", 32'(host_if.cmd_ready), 32'd1);
        check("rst_busy", 32'(host_if.busy), 32'd0);
        check("rst_done", 32'(host_if.done), 32'd0);
        check("rst_err", 32'(host_if.err_code), 32'd0);
        check("rst_rd_valid", 32'(host_if.rd_valid), 32'd0);
        check("rst_rd_data", 32'(host_if.rd_data), 32'd0);
        check("rst_gos", 32'({cond_go, wb_go, rb_go}), 32'd0);
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_cond_sel", 32'(cond_sel), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two-byte read, consumer always ready
        issue(7'h50, 8'd2, "t1");
        do_cond(2'd0, "t1_start");
        do_wb(1'b0, 8'hA1, "t1_addr");
        do_rb(8'hA5, 8, "t1_rb0");
        wait_rdv(8'hA5, "t1_byte0");
        do_cond(2'd2, "t1_ack");
        do_rb(8'h3C, 8, "t1_rb1");
        wait_rdv(8'h3C, "t1_byte1");
        do_cond(2'd3, "t1_nack");
        do_cond(2'd1, "t1_stop");
        wait_done(2'd0, "t1");
        check("t1_rd_data_hold", 32'(host_if.rd_data), 32'h3C);

        // Address probe that is NACKed
        base_r = rbr_cnt;
        base_v = rdv_cnt;
        issue(7'h21, 8'd0, "t2");
        do_cond(2'd0, "t2_start");
        do_wb(1'b1, 8'h43, "t2_addr");
        do_cond(2'd1, "t2_stop");
        wait_done(2'd1, "t2");
        check("t2_no_rb_go", 32'(rbr_cnt - base_r), 32'd0);
        check("t2_no_rd_valid", 32'(rdv_cnt - base_v), 32'd0);

        // Three bytes with a 50-cycle consumer stall after the first
        host_if.rd_ready = 1'b0;
        issue(7'h0F, 8'd3, "t3");
        do_cond(2'd0, "t3_start");
        do_wb(1'b0, 8'h1F, "t3_addr");
        do_rb(8'h11, 8, "t3_rb0");
        wait_rdv(8'h11, "t3_byte0");
        base_c = cgo_cnt;
        base_r = rbr_cnt;
        repeat (50) tick();
        check("t3_stall_valid", 32'(host_if.rd_valid), 32'd1);
        check("t3_stall_data", 32'(host_if.rd_data), 32'h11);
        check("t3_stall_no_cond", 32'(cgo_cnt - base_c), 32'd0);
        check("t3_stall_no_rb", 32'(rbr_cnt - base_r), 32'd0);
        check("t3_stall_bus", 32'(bus_sel), 32'd0);
        host_if.rd_ready = 1'b1;
        tick();
        check("t3_accept", 32'(host_if.rd_valid), 32'd0);
        do_cond(2'd2, "t3_ack0");
        do_rb(8'h22, 8, "t3_rb1");
        wait_rdv(8'h22, "t3_byte1");
        do_cond(2'd2, "t3_ack1");
        do_rb(8'h33, 8, "t3_rb2");
        wait_rdv(8'h33, "t3_byte2");
        do_cond(2'd3, "t3_nack");
        do_cond(2'd1, "t3_stop");
        wait_done(2'd0, "t3");

        // Read engine finishes after only seven bits
        base_v = rdv_cnt;
        issue(7'h3A, 8'd1, "t4");
        do_cond(2'd0, "t4_start");
        do_wb(1'b0, 8'h75, "t4_addr");
        do_rb(8'hFF, 7, "t4_rb");
        do_cond(2'd1, "t4_stop");
        wait_done(2'd2, "t4");
        check("t4_no_rd_valid", 32'(rdv_cnt - base_v), 32'd0);

        // Read engine never finishes: timeout after 16 go cycles
        issue(7'h12, 8'd1, "t5");
        do_cond(2'd0, "t5_start");
        do_wb(1'b0, 8'h25, "t5_addr");
        cnt = 0;
        while (rb_go !== 1'b1 && cnt < 40) begin tick(); cnt++; end
        check("t5_rb_go", 32'(rb_go), 32'd1);
        cnt = 0;
        while (rb_go === 1'b1 && cnt < 40) begin tick(); cnt++; end
        check("t5_go_cycles", 32'(cnt), 32'd16);
        check("t5_bus_release", 32'(bus_sel), 32'd0);
        do_cond(2'd1, "t5_stop");
        wait_done(2'd3, "t5");

        // Asynchronous reset in the middle of a read
        issue(7'h44, 8'd1, "t6");
        do_cond(2'd0, "t6_start");
        do_wb(1'b0, 8'h89, "t6_addr");
        cnt = 0;
        while (rb_go !== 1'b1 && cnt < 40) begin tick(); cnt++; end
        check("t6_rb_go", 32'(rb_go), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_gos", 32'({cond_go, wb_go, rb_go}), 32'd0);
        check("t6_rst_bus", 32'(bus_sel), 32'd0);
        check("t6_rst_busy", 32'(host_if.busy), 32'd0);
        check("t6_rst_ready", 32'(host_if.cmd_ready), 32'd1);
        check("t6_rst_rd_data", 32'(host_if.rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(7'h2D, 8'd1, "t6b");
        do_cond(2'd0, "t6b_start");
        do_wb(1'b0, 8'h5B, "t6b_addr");
        do_rb(8'h5A, 8, "t6b_rb");
        wait_rdv(8'h5A, "t6b_byte");
        do_cond(2'd3, "t6b_nack");
        do_cond(2'd1, "t6b_stop");
        wait_done(2'd0, "t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
